// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store buffer: widths, store-type codes,
// FSM states and the buffered entry layout.
package store_buffer_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned MEM_TYPE_LEN = 3;

    localparam logic [MEM_TYPE_LEN-1:0] MEM_B = 3'd0;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_H = 3'd1;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_W = 3'd2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic [XLEN-3:0] word;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wmask;
    } sb_entry_t;

endpackage

// File: rtl/mem_store_align.sv
// Turns a byte-addressed, right-justified store into a word address,
// lane-aligned data and byte mask; flags misaligned or illegal stores.
module mem_store_align
    import store_buffer_pkg::*;
(
    input  logic [XLEN-1:0]         addr_i,
    input  logic [XLEN-1:0]         data_i,
    input  logic [MEM_TYPE_LEN-1:0] type_i,
    output sb_entry_t               entry_o,
    output logic                    err_o
);

    logic [1:0] off;

    always_comb begin
        off           = addr_i[1:0];
        entry_o.word  = addr_i[XLEN-1:2];
        entry_o.wdata = data_i << {off, 3'b000};
        entry_o.wmask = '0;
        err_o         = 1'b0;
        case (type_i)
            MEM_B: entry_o.wmask = 4'b0001 << off;
            MEM_H: begin
                entry_o.wmask = 4'b0011 << off;
                err_o         = off[0];
            end
            MEM_W: begin
                entry_o.wmask = 4'b1111;
                err_o         = (off != 2'b00);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: queues aligned stores in a small circular array and
// drains them one at a time through a req/ack memory write port.
module store_buffer #(
    parameter int unsigned XLEN  = store_buffer_pkg::XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   st_valid,
    output logic                                   st_ready,
    input  logic [XLEN-1:0]                        st_addr,
    input  logic [XLEN-1:0]                        st_data,
    input  logic [store_buffer_pkg::MEM_TYPE_LEN-1:0] st_type,
    output logic                                   st_error,
    output logic                                   mem_req,
    input  logic                                   mem_ack,
    output logic [XLEN-1:0]                        mem_addr,
    output logic [XLEN-1:0]                        mem_wdata,
    output logic [3:0]                             mem_wmask,
    output logic                                   empty
);

    import store_buffer_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    sb_state_e        state_q;
    sb_entry_t        entries_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             st_error_q;

    sb_entry_t        new_entry;
    sb_entry_t        head;
    logic             align_err;
    logic             full, accept, push, pop;

    mem_store_align u_align (
        .addr_i  (st_addr),
        .data_i  (st_data),
        .type_i  (st_type),
        .entry_o (new_entry),
        .err_o   (align_err)
    );

    // Full blocks acceptance even when the head is being acked this cycle.
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign st_ready = !full && !reset;
    assign accept   = st_valid && st_ready;
    assign push     = accept && !align_err;
    assign pop      = (state_q == S_BUSY) && mem_ack;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            st_error_q <= 1'b0;
        end else begin
            st_error_q <= accept && align_err;
            count_q    <= count_d;
            if (push) begin
                entries_q[wr_ptr_q] <= new_entry;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case (state_q)
                S_IDLE:  if (push) state_q <= S_BUSY;
                S_BUSY:  if (count_d == '0) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign head      = entries_q[rd_ptr_q];
    assign mem_req   = (state_q == S_BUSY);
    assign mem_addr  = mem_req ? {head.word, 2'b00} : '0;
    assign mem_wdata = mem_req ? head.wdata : '0;
    assign mem_wmask = mem_req ? head.wmask : '0;
    assign st_error  = st_error_q;
    assign empty     = (count_q == '0);

endmodule
